// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch unit: issues sequential word fetches under a credit
// limit, tags in-order responses with their PC, and buffers them in a small
// queue for the decoder. Redirects flush the queue and drop stale responses.
// A misaligned redirect target parks the unit in FAULT until an aligned one.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0400_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_bits,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rec_wr;
    logic [PW-1:0] r_rec_rd;
    logic [PW-1:0] r_q_wr;
    logic [PW-1:0] r_q_rd;
    logic [31:0]   r_rec_pc [QDEPTH];
    logic [31:0]   r_q_bits [QDEPTH];
    logic [31:0]   r_q_pc   [QDEPTH];

    logic          w_aligned;
    logic          w_credit;
    logic          w_req_hs;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_occupancy;

    assign w_aligned   = (redirect_pc[1:0] == 2'b00);
    assign w_occupancy = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit    = (w_occupancy < QD);
    assign w_req_hs    = imem_req_valid && imem_req_ready;
    assign w_push      = imem_rsp_valid && !redirect_valid && (r_discard_cnt == '0);
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;

    assign imem_req_addr = r_fetch_pc;
    assign instr_valid   = (r_count != '0);
    assign instr_bits    = instr_valid ? r_q_bits[r_q_rd] : '0;
    assign instr_pc      = instr_valid ? r_q_pc[r_q_rd]   : '0;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: any redirect decides RUN vs FAULT by target alignment
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = w_aligned ? RUN : FAULT;
        end
    end

    // FSM outputs: request only in RUN, outside redirect cycles, with credit
    always_comb begin
        fetch_fault    = (r_state == FAULT);
        imem_req_valid = !rst && (r_state == RUN) && !redirect_valid && w_credit;
    end

    // Fetch PC and request-record write pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rec_wr   <= '0;
        end else if (redirect_valid) begin
            if (w_aligned) begin
                r_fetch_pc <= redirect_pc;
            end
        end else if (w_req_hs) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_rec_wr   <= r_rec_wr + PW'(1);
        end
    end

    // Per-request PC record storage, written at each request handshake
    always_ff @(posedge clk) begin
        if (w_req_hs) begin
            r_rec_pc[r_rec_wr] <= r_fetch_pc;
        end
    end

    // Outstanding count and record read pointer; every response retires one record,
    // including dropped ones, so records stay aligned with the in-order responses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_rec_rd      <= '0;
        end else begin
            if (imem_rsp_valid) begin
                r_rec_rd <= r_rec_rd + PW'(1);
            end
            case ({w_req_hs, imem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Count of stale responses still to be dropped after a redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_discard_cnt <= '0;
        end else if (redirect_valid) begin
            r_discard_cnt <= r_outstanding - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (r_discard_cnt != '0)) begin
            r_discard_cnt <= r_discard_cnt - CW'(1);
        end
    end

    // Instruction queue pointers and occupancy; a redirect empties it
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_wr <= r_q_wr + PW'(1);
            end
            if (w_pop) begin
                r_q_rd <= r_q_rd + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Instruction queue storage: word plus the PC recorded for its request
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_bits[r_q_wr] <= imem_rsp_data;
            r_q_pc[r_q_wr]   <= r_rec_pc[r_rec_rd];
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Self-checking bench for rv32i_fetch_unit: an in-order memory responder with
// programmable latency, a queue-based reference model checked every cycle, and
// directed scenarios with literal expectations.
module tb_rv32i_fetch_unit;

    localparam logic [31:0] RPC = 32'h0400_0000;
    localparam int          QD  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_bits;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    rv32i_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_bits     (instr_bits),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Memory responder and reference model state
    int unsigned mem_lat = 1;
    int unsigned ecyc    = 0;
    logic [31:0] pend_addr[$];
    int unsigned pend_due[$];

    logic [31:0] m_q[$];
    logic [31:0] m_fl_pc[$];
    bit          m_fl_stale[$];
    logic [31:0] m_pc;
    bit          m_fault;
    bit          m_known = 1'b0;
    bit          e_req;
    bit          r_got;
    bit          r_stale;
    logic [31:0] r_pc;

    initial begin : engine
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (pend_due.size() > 0 && pend_due[0] <= ecyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            #4;
            e_req = !rst && m_known && !m_fault && !redirect_valid &&
                    ((m_fl_pc.size() + m_q.size()) < QD);
            if (m_known) begin
                chk("m_req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
                chk("m_req_addr", imem_req_addr, m_pc);
                chk("m_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
                if (m_q.size() > 0) begin
                    chk("m_instr_valid", {31'b0, instr_valid}, 32'd1);
                    chk("m_instr_pc", instr_pc, m_q[0]);
                    chk("m_instr_bits", instr_bits, mem_word(m_q[0]));
                end else begin
                    chk("m_instr_valid", {31'b0, instr_valid}, 32'd0);
                    chk("m_instr_pc", instr_pc, 32'd0);
                    chk("m_instr_bits", instr_bits, 32'd0);
                end
            end
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(ecyc + mem_lat);
            end
            if (rst) begin
                m_pc    = RPC;
                m_fault = 1'b0;
                m_q.delete();
                m_fl_pc.delete();
                m_fl_stale.delete();
                m_known = 1'b1;
            end else if (m_known) begin
                r_got = 1'b0;
                if (imem_rsp_valid && m_fl_pc.size() > 0) begin
                    r_pc    = m_fl_pc.pop_front();
                    r_stale = m_fl_stale.pop_front();
                    r_got   = 1'b1;
                end
                if (redirect_valid) begin
                    m_q.delete();
                    foreach (m_fl_stale[i]) m_fl_stale[i] = 1'b1;
                    if (redirect_pc[1:0] == 2'b00) begin
                        m_pc    = redirect_pc;
                        m_fault = 1'b0;
                    end else begin
                        m_fault = 1'b1;
                    end
                end else begin
                    if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
                    if (r_got && !r_stale) m_q.push_back(r_pc);
                    if (e_req && imem_req_ready) begin
                        m_fl_pc.push_back(m_pc);
                        m_fl_stale.push_back(1'b0);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            ecyc++;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got time limit reached, expected end of directed sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic smp();
        #4;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0;
        smp();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        smp();
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    endtask

    int unsigned nreq;
    int unsigned nfault;
    bit          found;
    logic [15:0] pat_rdy = 16'b1011_0111_1101_0110;
    logic [15:0] pat_ir  = 16'b0110_1101_1001_1110;

    initial begin : main
        rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; instr_ready = 1'b0;

        // Reset state
        cyc(); smp();
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("reset_instr_bits", instr_bits, 32'd0);
        chk("reset_instr_pc", instr_pc, 32'd0);
        chk("reset_fault", {31'b0, fetch_fault}, 32'd0);

        // Streaming, 1-cycle latency
        do_reset();
        cyc(); rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 1; smp();
        chk("st_req0_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("st_req0_addr", imem_req_addr, 32'h0400_0000);
        chk("st_iv0", {31'b0, instr_valid}, 32'd0);
        cyc(); smp();
        chk("st_req1_addr", imem_req_addr, 32'h0400_0004);
        chk("st_iv1", {31'b0, instr_valid}, 32'd0);
        cyc(); smp();
        chk("st_iv2", {31'b0, instr_valid}, 32'd1);
        chk("st_pc2", instr_pc, 32'h0400_0000);
        chk("st_bits2", instr_bits, 32'h1357_9FDF);
        chk("st_req2_addr", imem_req_addr, 32'h0400_0008);
        cyc(); smp();
        chk("st_pc3", instr_pc, 32'h0400_0004);
        repeat (6) begin cyc(); smp(); end

        // Backpressure: credit stops requests at queue depth
        do_reset();
        nreq = 0;
        cyc(); rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b0; mem_lat = 1; smp();
        if (imem_req_valid && imem_req_ready) nreq++;
        repeat (9) begin
            cyc(); smp();
            if (imem_req_valid && imem_req_ready) nreq++;
        end
        chk("bp_req_count", nreq, 32'd4);
        chk("bp_req_stalled", {31'b0, imem_req_valid}, 32'd0);
        chk("bp_head_pc", instr_pc, 32'h0400_0000);
        cyc(); instr_ready = 1'b1; smp();
        chk("bp_full_no_req", {31'b0, imem_req_valid}, 32'd0);
        cyc(); instr_ready = 1'b0; smp();
        chk("bp_resume_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("bp_resume_addr", imem_req_addr, 32'h0400_0010);
        chk("bp_head_after_pop", instr_pc, 32'h0400_0004);
        nreq = 0;
        if (imem_req_valid && imem_req_ready) nreq++;
        repeat (7) begin
            cyc(); smp();
            if (imem_req_valid && imem_req_ready) nreq++;
        end
        chk("bp_one_more_req", nreq, 32'd1);

        // Redirect with three requests in flight
        do_reset();
        cyc(); rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 4; smp();
        cyc(); smp();
        cyc(); smp();
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0400_0040; smp();
        chk("rd_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        cyc(); redirect_valid = 1'b0; smp();
        chk("rd_queue_empty", {31'b0, instr_valid}, 32'd0);
        chk("rd_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rd_req_addr", imem_req_addr, 32'h0400_0040);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(); smp();
            if (instr_valid) found = 1'b1;
        end
        chk("rd_delivered", {31'b0, found}, 32'd1);
        chk("rd_first_pc", instr_pc, 32'h0400_0040);
        chk("rd_first_bits", instr_bits, 32'h1317_9FDF);

        // Misaligned redirect -> FAULT, then recovery
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0400_0042; smp();
        chk("ft_redirect_cycle_req", {31'b0, imem_req_valid}, 32'd0);
        cyc(); redirect_valid = 1'b0; smp();
        chk("ft_flushed", {31'b0, instr_valid}, 32'd0);
        nfault = 0;
        if (fetch_fault && !imem_req_valid) nfault++;
        repeat (11) begin
            cyc(); smp();
            if (fetch_fault && !imem_req_valid) nfault++;
        end
        chk("ft_held_cycles", nfault, 32'd12);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0400_0000; smp();
        chk("ft_still_fault", {31'b0, fetch_fault}, 32'd1);
        cyc(); redirect_valid = 1'b0; smp();
        chk("ft_cleared", {31'b0, fetch_fault}, 32'd0);
        chk("ft_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("ft_req_addr", imem_req_addr, 32'h0400_0000);
        repeat (8) begin cyc(); smp(); end

        // Address wrap at the top of the 32-bit space
        do_reset();
        cyc(); rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; smp();
        chk("wr_redirect_req", {31'b0, imem_req_valid}, 32'd0);
        cyc(); redirect_valid = 1'b0; smp();
        chk("wr_req0_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("wr_req0_addr", imem_req_addr, 32'hFFFF_FFFC);
        cyc(); smp();
        chk("wr_req1_addr", imem_req_addr, 32'h0000_0000);
        cyc(); smp();
        chk("wr_pc0", instr_pc, 32'hFFFF_FFFC);
        chk("wr_bits0", instr_bits, 32'hECAB_6420);
        cyc(); smp();
        chk("wr_pc1", instr_pc, 32'h0000_0000);
        chk("wr_bits1", instr_bits, 32'h1357_9BDF);

        // Reset in the middle of operation with entries queued and in flight
        do_reset();
        cyc(); rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b0; mem_lat = 2; smp();
        repeat (4) begin cyc(); smp(); end
        chk("mr_queued", {31'b0, instr_valid}, 32'd1);
        cyc(); rst = 1'b1; smp();
        chk("mr_rst_req", {31'b0, imem_req_valid}, 32'd0);
        cyc(); rst = 1'b0; smp();
        chk("mr_flushed", {31'b0, instr_valid}, 32'd0);
        chk("mr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("mr_req_addr", imem_req_addr, RPC);
        repeat (6) begin cyc(); smp(); end

        // Mixed ready patterns with a mid-stream redirect, checked by the model
        do_reset();
        cyc(); rst = 1'b0; mem_lat = 3;
        imem_req_ready = pat_rdy[0]; instr_ready = pat_ir[0]; smp();
        for (int i = 1; i < 48; i++) begin
            cyc();
            imem_req_ready = pat_rdy[4'(i)];
            instr_ready    = pat_ir[4'(i * 3)];
            redirect_valid = (i == 20);
            redirect_pc    = 32'h0400_0100;
            smp();
        end
        cyc(); redirect_valid = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1; smp();
        repeat (10) begin cyc(); smp(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
